// File: rtl/serial_add_sub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {OP_ADD, OP_SUB} op_t;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder shared by the serial datapath (module full_adder).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic co,
    output logic sum
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial signed adder/subtractor, LSB-first, one full_adder, N+1 edges start-to-done.
// Optional signed overflow flag enabled by defining SERIAL_OVF_EN.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         co,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a_sh;
    logic [N-1:0]   r_b_sh;
    logic [N-2:0]   r_res;
    logic [N-1:0]   r_s;
    logic           r_carry;
    logic           r_co;
    logic [CW-1:0]  r_count;
    logic           w_accept;
    logic           w_last;
    logic           w_sum;
    logic           w_fa_co;
    logic [N-1:0]   w_shift;

    full_adder fa (
        .a   (r_a_sh[0]),
        .b   (r_b_sh[0]),
        .ci  (r_carry),
        .co  (w_fa_co),
        .sum (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_count == LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Partial sum collects in r_res; S only changes once the final bit lands.
    assign w_shift = {w_sum, r_res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a_sh  <= A;
            r_b_sh  <= (op_t'(op) == OP_SUB) ? ~B : B;
            r_carry <= ci ^ op;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_res   <= w_shift[N-1:1];
            r_carry <= w_fa_co;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_s  <= w_shift;
                r_co <= w_fa_co;
            end
        end
    end

    assign S  = r_s;
    assign co = r_co;

`ifdef SERIAL_OVF_EN
    logic r_ovf;

    // r_carry holds the carry into bit N-1 while that bit is processed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_fa_co;
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (N=4) with an expected-result queue.
module tb_serial_add_sub;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         ci = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;

    exp_t         q[$];
    int           pass_cnt = 0;
    int           total = 0;
    logic [N-1:0] last_exp_s = '0;

    serial_add_sub #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic o, input logic c);
        exp_t e;
        int   u;
        int   sv;
        int   sa;
        int   sb;
        sa = $signed(a);
        sb = $signed(b);
        if (!o) begin
            u    = int'(a) + int'(b) + int'(c);
            sv   = sa + sb + int'(c);
            e.co = (u >= (1 << N));
        end else begin
            u    = int'(a) - int'(b) - int'(c);
            sv   = sa - sb - int'(c);
            e.co = (u >= 0);
        end
        e.s = N'(u);
`ifdef SERIAL_OVF_EN
        e.ovf = (sv > (1 << (N - 1)) - 1) || (sv < -(1 << (N - 1)));
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    // Drives one start pulse, queues the expectation, waits (bounded) for done.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic iop, input logic ici,
                          output logic [N-1:0] gs, output logic gco,
                          output logic govf, output logic gbusy, output int lat);
        bit seen;
        @(negedge clk);
        A = ia; B = ib; op = iop; ci = ici; start = 1'b1;
        q.push_back(model(ia, ib, iop, ici));
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= N + 8 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat  = i;
                seen = 1;
            end
        end
        gs = S; gco = co; govf = ovf; gbusy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({busy, done, S, co, ovf} !== '0) $display("FAIL reset_outputs: got %b required %b", {busy, done, S, co, ovf}, 8'b0); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", busy); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [N-1:0] va[4] = '{4'd5, 4'd7, 4'd2, 4'b1000};
        logic [N-1:0] vb[4] = '{4'd3, 4'd2, 4'd5, 4'b1111};
        logic         vo[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [N-1:0] gs;
        logic gco, govf, gbusy;
        int lat;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            run_op(va[k], vb[k], vo[k], vc[k], gs, gco, govf, gbusy, lat);
            e = q.pop_front();
            last_exp_s = e.s;
            total++; if (lat !== N + 1) $display("FAIL dir_latency[%0d]: got %0d required %0d", k, lat, N + 1); else pass_cnt++;
            total++; if (gs !== e.s) $display("FAIL dir_S[%0d]: got %b required %b", k, gs, e.s); else pass_cnt++;
            total++; if (gco !== e.co) $display("FAIL dir_co[%0d]: got %b required %b", k, gco, e.co); else pass_cnt++;
            total++; if (govf !== e.ovf) $display("FAIL dir_ovf[%0d]: got %b required %b", k, govf, e.ovf); else pass_cnt++;
            total++; if (gbusy !== 1'b1) $display("FAIL dir_busy_with_done[%0d]: got %b required 1", k, gbusy); else pass_cnt++;
            @(negedge clk);
            total++; if ({done, busy} !== 2'b00) $display("FAIL dir_done_one_cycle[%0d]: got done,busy=%b required 00", k, {done, busy}); else pass_cnt++;
            total++; if (S !== e.s) $display("FAIL dir_S_hold[%0d]: got %b required %b", k, S, e.s); else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        bit   seen = 0;
        bit   s_moved = 0;
        int   lat = 0;
        exp_t e;
        @(negedge clk);
        A = 4'd3; B = 4'd2; op = 1'b0; ci = 1'b0; start = 1'b1;
        q.push_back(model(4'd3, 4'd2, 1'b0, 1'b0));
        for (int i = 1; i <= N + 8 && !seen; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 3);
            if (i == 2) begin A = 4'd7; B = 4'd7; op = 1'b1; ci = 1'b1; end
            if (!done && S !== last_exp_s) s_moved = 1;
            if (done) begin lat = i; seen = 1; end
        end
        start = 1'b0;
        e = q.pop_front();
        total++; if (lat !== N + 1) $display("FAIL ign_latency: got %0d required %0d", lat, N + 1); else pass_cnt++;
        total++; if (s_moved) $display("FAIL ign_S_stable_in_run: got moved required %b held", last_exp_s); else pass_cnt++;
        total++; if ({S, co, ovf} !== {e.s, e.co, e.ovf}) $display("FAIL ign_result: got %b required %b", {S, co, ovf}, {e.s, e.co, e.ovf}); else pass_cnt++;
        last_exp_s = e.s;
        seen = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (busy || done) seen = 1;
        end
        total++; if (seen) $display("FAIL ign_no_queued_op: got busy required idle"); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] gs;
        logic gco, govf, gbusy;
        int lat;
        exp_t e;
        @(negedge clk);
        A = 4'd6; B = 4'd5; op = 1'b0; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({busy, done, S, co, ovf} !== '0) $display("FAIL mid_reset_outputs: got %b required %b", {busy, done, S, co, ovf}, 8'b0); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        last_exp_s = '0;
        run_op(4'd4, 4'd9, 1'b1, 1'b0, gs, gco, govf, gbusy, lat);
        e = q.pop_front();
        last_exp_s = e.s;
        total++; if (lat !== N + 1) $display("FAIL post_reset_latency: got %0d required %0d", lat, N + 1); else pass_cnt++;
        total++; if ({gs, gco, govf} !== {e.s, e.co, e.ovf}) $display("FAIL post_reset_result: got %b required %b", {gs, gco, govf}, {e.s, e.co, e.ovf}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] gs;
        logic gco, govf, gbusy;
        int lat;
        int errs = 0;
        exp_t e;
        for (int k = 0; k < 300; k++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), gs, gco, govf, gbusy, lat);
            if (q.size() == 0) begin
                total++; $display("FAIL b2b_queue_empty[%0d]: got 0 entries required 1", k);
            end else begin
                e = q.pop_front();
                total++; if (lat !== N + 1) begin $display("FAIL b2b_latency[%0d]: got %0d required %0d", k, lat, N + 1); errs++; end else pass_cnt++;
                total++; if ({gs, gco, govf} !== {e.s, e.co, e.ovf}) begin $display("FAIL b2b_result[%0d]: got %b required %b", k, {gs, gco, govf}, {e.s, e.co, e.ovf}); errs++; end else pass_cnt++;
            end
            if (errs > 10) break;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
